// File: rtl/ctrl_pkt_buffer.sv
`default_nettype none
// ctrl_pkt_buffer: store-and-forward buffer re-issuing whole control packets on a back-pressured AXIS master.
// Revision: 1.0 - initial release
module ctrl_pkt_buffer #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int DEPTH_LOG2           = 4
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [31:0]                       drop_cnt,
  output logic [31:0]                       pkt_cnt
);

  localparam int DW    = C_S_AXIS_DATA_WIDTH;
  localparam int KW    = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW    = C_S_AXIS_TUSER_WIDTH;
  localparam int EW    = DW + KW + UW + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;

  logic [EW-1:0]       mem [0:DEPTH-1];
  logic [1:0]          state;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] wr_tmp;
  logic [DEPTH_LOG2:0] used;
  logic                free;
  logic                store;
  logic                commit;
  logic                drop_evt;
  logic                load;

  // Occupancy never exceeds DEPTH, so the MSB alone tells "full" from "has room".
  assign used     = wr_tmp - rd_ptr;
  assign free     = ~used[DEPTH_LOG2];
  assign store    = s_axis_tvalid && free && (state != S_DROP);
  assign commit   = store && s_axis_tlast;
  assign drop_evt = s_axis_tvalid && s_axis_tlast && ((state == S_DROP) || !free);
  assign load     = (rd_ptr != wr_ptr) && (!m_axis_tvalid || m_axis_tready);

  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_tmp[DEPTH_LOG2-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= S_IDLE;
      wr_ptr <= '0;
      wr_tmp <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (s_axis_tvalid) begin
            if (free) begin
              wr_tmp <= wr_tmp + 1'b1;
              if (s_axis_tlast) wr_ptr <= wr_tmp + 1'b1;
              else              state  <= S_WRITE;
            end else if (!s_axis_tlast) begin
              state <= S_DROP;
            end
          end
        end
        S_WRITE: begin
          if (s_axis_tvalid) begin
            if (free) begin
              wr_tmp <= wr_tmp + 1'b1;
              if (s_axis_tlast) begin
                wr_ptr <= wr_tmp + 1'b1;
                state  <= S_IDLE;
              end
            end else begin
              // Roll back the partial packet so it can never become readable.
              wr_tmp <= wr_ptr;
              state  <= s_axis_tlast ? S_IDLE : S_DROP;
            end
          end
        end
        S_DROP: begin
          if (s_axis_tvalid && s_axis_tlast) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (commit) pkt_cnt <= pkt_cnt + 32'd1;
      if (drop_evt && (drop_cnt != 32'hFFFF_FFFF)) drop_cnt <= drop_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (load) begin
      {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} <= mem[rd_ptr[DEPTH_LOG2-1:0]];
      m_axis_tvalid <= 1'b1;
      rd_ptr        <= rd_ptr + 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pkt_buffer.sv
`default_nettype none
// tb_ctrl_pkt_buffer: randomized bench comparing ctrl_pkt_buffer against a queue-based packet model.
// Revision: 1.0 - initial release
module tb_ctrl_pkt_buffer;

  localparam int DW    = 512;
  localparam int KW    = DW / 8;
  localparam int UW    = 128;
  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;
  localparam int EW    = DW + KW + UW + 1;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic [31:0]   drop_cnt;
  logic [31:0]   pkt_cnt;

  ctrl_pkt_buffer #(
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .DEPTH_LOG2          (DL2)
  ) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .drop_cnt     (drop_cnt),
    .pkt_cnt      (pkt_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [767:0] got, input logic [767:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: committed beats waiting in the buffer, the packet being
  // assembled, the output slot, and packet/drop tallies.
  logic [EW-1:0] cq[$];
  logic [EW-1:0] pq[$];
  logic          mod_ov = 1'b0;
  logic [EW-1:0] mod_ob = '0;
  bit            mod_dropping = 1'b0;
  logic [31:0]   mod_pkts = '0;
  logic [31:0]   mod_drops = '0;
  int            rx_beats = 0;
  int            rx_lasts = 0;
  bit            rnd_ready = 1'b0;

  always @(posedge clk or negedge aresetn) begin
    bit has_room;
    bit take;
    if (!aresetn) begin
      cq.delete();
      pq.delete();
      mod_ov       = 1'b0;
      mod_ob       = '0;
      mod_dropping = 1'b0;
      mod_pkts     = '0;
      mod_drops    = '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        rx_beats++;
        if (m_axis_tlast) rx_lasts++;
      end
      has_room = (cq.size() + pq.size()) < DEPTH;
      take     = (cq.size() != 0) && (!mod_ov || m_axis_tready);
      if (s_axis_tvalid) begin
        if (mod_dropping) begin
          if (s_axis_tlast) begin
            mod_dropping = 1'b0;
            if (mod_drops != 32'hFFFF_FFFF) mod_drops++;
          end
        end else if (has_room) begin
          pq.push_back({s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast});
          if (s_axis_tlast) begin
            foreach (pq[i]) cq.push_back(pq[i]);
            pq.delete();
            mod_pkts++;
          end
        end else begin
          pq.delete();
          if (s_axis_tlast) begin
            if (mod_drops != 32'hFFFF_FFFF) mod_drops++;
          end else begin
            mod_dropping = 1'b1;
          end
        end
      end
      if (take) begin
        mod_ob = cq.pop_front();
        mod_ov = 1'b1;
      end else if (mod_ov && m_axis_tready) begin
        mod_ov = 1'b0;
      end
    end
  end

  task automatic compare_all();
    check("tvalid", m_axis_tvalid, mod_ov);
    if (mod_ov) check("beat", {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}, mod_ob);
    check("pkt_cnt", pkt_cnt, mod_pkts);
    check("drop_cnt", drop_cnt, mod_drops);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    compare_all();
    if (rnd_ready) m_axis_tready = 1'($urandom_range(1));
  endtask

  function automatic logic [EW-1:0] rand_beat(input bit last);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    for (int i = 0; i < KW / 32; i++) k[i*32 +: 32] = $urandom;
    for (int i = 0; i < UW / 32; i++) u[i*32 +: 32] = $urandom;
    return {d, k, u, last};
  endfunction

  task automatic send_beats(input int n, input bit with_last, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_axis_tvalid = 1'b0;
        cyc();
      end
      {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast} = rand_beat(with_last && (i == n - 1));
      s_axis_tvalid = 1'b1;
      cyc();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  function automatic bit busy();
    return (cq.size() != 0) || (pq.size() != 0) || mod_ov || m_axis_tvalid;
  endfunction

  task automatic drain();
    rnd_ready     = 1'b0;
    m_axis_tready = 1'b1;
    for (int k = 0; k < 300 && busy(); k++) cyc();
    check("drain_timeout", busy(), 1'b0);
  endtask

  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    aresetn       = 1'b0;
    cyc();
    check("reset_outs", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast,
                         drop_cnt, pkt_cnt}, '0);
    aresetn  = 1'b1;
    rx_beats = 0;
    rx_lasts = 0;
    cyc();
  endtask

  initial begin
    int sent;

    do_reset();

    // T1: single 4-beat packet, output free; first beat one edge after commit.
    m_axis_tready = 1'b1;
    send_beats(4, 1'b1, 0);
    check("t1_lat_e0", m_axis_tvalid, 1'b0);
    cyc();
    check("t1_lat_e1", m_axis_tvalid, 1'b1);
    drain();
    check("t1_beats", rx_beats, 4);
    check("t1_lasts", rx_lasts, 1);
    check("t1_pkt", pkt_cnt, 32'd1);
    check("t1_drop", drop_cnt, 32'd0);

    // T2: stalled output, two packets, then release.
    do_reset();
    m_axis_tready = 1'b0;
    send_beats(3, 1'b1, 0);
    send_beats(5, 1'b1, 30);
    repeat (10) cyc();
    drain();
    check("t2_beats", rx_beats, 8);
    check("t2_lasts", rx_lasts, 2);
    check("t2_pkt", pkt_cnt, 32'd2);

    // T3: third 6-beat packet overflows a stalled 16-entry buffer.
    do_reset();
    m_axis_tready = 1'b0;
    repeat (3) send_beats(6, 1'b1, 0);
    check("t3_drop", drop_cnt, 32'd1);
    check("t3_pkt", pkt_cnt, 32'd2);
    drain();
    check("t3_beats", rx_beats, 12);
    m_axis_tready = 1'b0;
    send_beats(6, 1'b1, 0);
    check("t3_pkt_after", pkt_cnt, 32'd3);
    drain();

    // T4: packet longer than the buffer is dropped even from empty.
    do_reset();
    m_axis_tready = 1'b0;
    send_beats(20, 1'b1, 0);
    check("t4_drop", drop_cnt, 32'd1);
    check("t4_no_valid", m_axis_tvalid, 1'b0);
    send_beats(2, 1'b1, 0);
    drain();
    check("t4_beats", rx_beats, 2);
    check("t4_pkt", pkt_cnt, 32'd1);

    // T5: reset after beat 2; the remaining beats form a fresh packet.
    do_reset();
    m_axis_tready = 1'b1;
    send_beats(2, 1'b0, 0);
    aresetn = 1'b0;
    cyc();
    check("t5_reset_outs", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast,
                            drop_cnt, pkt_cnt}, '0);
    aresetn  = 1'b1;
    rx_beats = 0;
    rx_lasts = 0;
    send_beats(2, 1'b1, 0);
    drain();
    check("t5_beats", rx_beats, 2);
    check("t5_lasts", rx_lasts, 1);
    check("t5_pkt", pkt_cnt, 32'd1);

    // T6: maximum-length packet fills the buffer, then new packets arrive while draining.
    do_reset();
    m_axis_tready = 1'b0;
    send_beats(DEPTH, 1'b1, 0);
    check("t6_max_pkt", pkt_cnt, 32'd1);
    check("t6_max_drop", drop_cnt, 32'd0);
    m_axis_tready = 1'b1;
    send_beats(4, 1'b1, 0);
    send_beats(DEPTH, 1'b1, 0);
    drain();
    check("t6_total", pkt_cnt + drop_cnt, 32'd3);

    // Random traffic with random back-pressure and idle gaps.
    do_reset();
    sent      = 0;
    rnd_ready = 1'b1;
    repeat (60) begin
      send_beats(int'($urandom_range(1, 20)), 1'b1, 20);
      sent++;
      if ($urandom_range(3) == 0) repeat (int'($urandom_range(1, 8))) cyc();
    end
    drain();
    check("rand_total", pkt_cnt + drop_cnt, sent);
    check("rand_lasts", rx_lasts, pkt_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
